// File: rtl/ghost_mode_ctrl.sv
`default_nettype none
// ghost_mode_ctrl: per-ghost SCATTER/CHASE/FRIGHT/EATEN controller with
// direction-reverse pulse, fright countdown/flash and registered target tile.
// Revision: 1.0

module ghost_mode_ctrl #(
  parameter int unsigned FRIGHT_SECS = 6,
  parameter int unsigned FLASH_SECS  = 2,
  parameter logic [4:0]  SCATTER_X   = 5'd27,
  parameter logic [4:0]  SCATTER_Y   = 5'd0,
  parameter logic [4:0]  HOME_X      = 5'd13,
  parameter logic [4:0]  HOME_Y      = 5'd14,
  parameter logic [9:0]  LFSR_SEED   = 10'h2A5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_hz_enable,
  input  logic       chase,
  input  logic       pellet_eaten,
  input  logic       ghost_eaten,
  input  logic       ghost_at_home,
  input  logic [4:0] pac_x,
  input  logic [4:0] pac_y,
  output logic [1:0] mode,
  output logic       reverse,
  output logic [4:0] target_x,
  output logic [4:0] target_y,
  output logic       frightened_flash
);

  localparam logic [1:0] MODE_SCATTER = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_FRIGHT  = 2'd2;
  localparam logic [1:0] MODE_EATEN   = 2'd3;

  localparam logic [3:0] FRIGHT_LOAD = 4'(FRIGHT_SECS);
  localparam logic [3:0] FLASH_CNT   = 4'(FLASH_SECS);

  logic [1:0] mode_q, mode_d;
  logic       chase_q;
  logic       reverse_q, reverse_d;
  logic [3:0] fright_cnt_q, fright_cnt_d;
  logic [9:0] lfsr_q, lfsr_d;
  logic [4:0] target_x_q, target_x_d;
  logic [4:0] target_y_q, target_y_d;
  logic       flash_q, flash_d;
  logic       fright_entry_q, fright_entry_d;
  logic       chase_edge;
  logic [1:0] resume_mode;

  assign chase_edge  = chase != chase_q;
  assign resume_mode = chase ? MODE_CHASE : MODE_SCATTER;

  always_comb begin
    mode_d       = mode_q;
    fright_cnt_d = fright_cnt_q;
    reverse_d    = 1'b0;
    case (mode_q)
      MODE_SCATTER, MODE_CHASE: begin
        if (pellet_eaten) begin
          mode_d       = MODE_FRIGHT;
          fright_cnt_d = FRIGHT_LOAD;
          reverse_d    = 1'b1;
        end else if (chase_edge) begin
          mode_d    = resume_mode;
          reverse_d = 1'b1;
        end
      end
      MODE_FRIGHT: begin
        if (ghost_eaten) begin
          mode_d       = MODE_EATEN;
          fright_cnt_d = 4'd0;
        end else if (pellet_eaten) begin
          fright_cnt_d = FRIGHT_LOAD;
        end else if (one_hz_enable) begin
          if (fright_cnt_q == 4'd1) begin
            fright_cnt_d = 4'd0;
            mode_d       = resume_mode;
          end else if (fright_cnt_q != 4'd0) begin
            fright_cnt_d = fright_cnt_q - 4'd1;
          end
        end
      end
      MODE_EATEN: begin
        if (ghost_at_home) begin
          mode_d = resume_mode;
        end
      end
      default: mode_d = MODE_CHASE;
    endcase
  end

  assign fright_entry_d = (mode_d == MODE_FRIGHT) && (mode_q != MODE_FRIGHT);
  assign flash_d = (mode_d == MODE_FRIGHT) && (fright_cnt_d != 4'd0) &&
                   (fright_cnt_d <= FLASH_CNT);
  assign lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

  // Target follows the mode already presented on the outputs, one cycle behind.
  always_comb begin
    target_x_d = target_x_q;
    target_y_d = target_y_q;
    case (mode_q)
      MODE_CHASE: begin
        target_x_d = pac_x;
        target_y_d = pac_y;
      end
      MODE_SCATTER: begin
        target_x_d = SCATTER_X;
        target_y_d = SCATTER_Y;
      end
      MODE_FRIGHT: begin
        if (fright_entry_q || one_hz_enable) begin
          target_x_d = lfsr_q[4:0];
          target_y_d = lfsr_q[9:5];
        end
      end
      default: begin
        target_x_d = HOME_X;
        target_y_d = HOME_Y;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q         <= MODE_CHASE;
      chase_q        <= 1'b1;
      reverse_q      <= 1'b0;
      fright_cnt_q   <= 4'd0;
      lfsr_q         <= LFSR_SEED;
      target_x_q     <= 5'd0;
      target_y_q     <= 5'd0;
      flash_q        <= 1'b0;
      fright_entry_q <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      chase_q        <= chase;
      reverse_q      <= reverse_d;
      fright_cnt_q   <= fright_cnt_d;
      lfsr_q         <= lfsr_d;
      target_x_q     <= target_x_d;
      target_y_q     <= target_y_d;
      flash_q        <= flash_d;
      fright_entry_q <= fright_entry_d;
    end
  end

  assign mode             = mode_q;
  assign reverse          = reverse_q;
  assign target_x         = target_x_q;
  assign target_y         = target_y_q;
  assign frightened_flash = flash_q;

endmodule

`default_nettype wire

// File: tb/tb_ghost_mode_ctrl.sv
`default_nettype none
// tb_ghost_mode_ctrl: directed and randomized checks of ghost_mode_ctrl
// against a behavioural model of the ghost rules.

module tb_ghost_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_hz_enable = 1'b0;
  logic       chase = 1'b1;
  logic       pellet_eaten = 1'b0;
  logic       ghost_eaten = 1'b0;
  logic       ghost_at_home = 1'b0;
  logic [4:0] pac_x = 5'd0;
  logic [4:0] pac_y = 5'd0;
  logic [1:0] mode;
  logic       reverse;
  logic [4:0] target_x;
  logic [4:0] target_y;
  logic       frightened_flash;

  int checks = 0;
  int errors = 0;

  // Behavioural model state (plain integers).
  int  e_mode, e_cnt, e_lfsr, e_tx, e_ty;
  bit  e_chase, e_rev, e_flash, e_fresh;

  ghost_mode_ctrl dut (
    .clk(clk), .reset(reset), .one_hz_enable(one_hz_enable), .chase(chase),
    .pellet_eaten(pellet_eaten), .ghost_eaten(ghost_eaten),
    .ghost_at_home(ghost_at_home), .pac_x(pac_x), .pac_y(pac_y),
    .mode(mode), .reverse(reverse), .target_x(target_x), .target_y(target_y),
    .frightened_flash(frightened_flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int want, nm, ncnt, fb;
    bit nrev, nfresh;
    if (reset) begin
      e_mode = 1; e_chase = 1; e_rev = 0; e_cnt = 0; e_lfsr = 'h2A5;
      e_tx = 0; e_ty = 0; e_flash = 0; e_fresh = 0;
      return;
    end
    if (e_mode == 1) begin e_tx = pac_x; e_ty = pac_y; end
    else if (e_mode == 0) begin e_tx = 27; e_ty = 0; end
    else if (e_mode == 3) begin e_tx = 13; e_ty = 14; end
    else if (e_fresh || one_hz_enable) begin e_tx = e_lfsr % 32; e_ty = e_lfsr / 32; end
    want = chase ? 1 : 0;
    nm = e_mode; ncnt = e_cnt; nrev = 0; nfresh = 0;
    if (e_mode <= 1) begin
      if (pellet_eaten) begin nm = 2; ncnt = 6; nrev = 1; nfresh = 1; end
      else if (chase != e_chase) begin nm = want; nrev = 1; end
    end else if (e_mode == 2) begin
      if (ghost_eaten) begin nm = 3; ncnt = 0; end
      else if (pellet_eaten) ncnt = 6;
      else if (one_hz_enable && e_cnt >= 1) begin
        ncnt = e_cnt - 1;
        if (ncnt == 0) nm = want;
      end
    end else if (ghost_at_home) begin
      nm = want;
    end
    fb = ((e_lfsr >> 9) ^ (e_lfsr >> 6)) & 1;
    e_lfsr = ((e_lfsr * 2) % 1024) + fb;
    e_mode = nm; e_cnt = ncnt; e_rev = nrev; e_fresh = nfresh;
    e_chase = chase;
    e_flash = (nm == 2) && (ncnt >= 1) && (ncnt <= 2);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("mode", 32'(mode), 32'(e_mode));
    chk("reverse", 32'(reverse), 32'(e_rev));
    chk("target_x", 32'(target_x), 32'(e_tx));
    chk("target_y", 32'(target_y), 32'(e_ty));
    chk("flash", 32'(frightened_flash), 32'(e_flash));
  endtask

  task automatic step(input bit pel, input bit ge, input bit home, input bit hz);
    pellet_eaten = pel; ghost_eaten = ge; ghost_at_home = home; one_hz_enable = hz;
    tick();
    pellet_eaten = 0; ghost_eaten = 0; ghost_at_home = 0; one_hz_enable = 0;
  endtask

  task automatic strobe_and_gap();
    step(0, 0, 0, 1);
    tick();
  endtask

  initial begin
    // Reset
    reset = 1; tick(); tick();
    reset = 0;
    chk("reset_mode", 32'(mode), 32'd1);
    chk("reset_target", 32'({target_x, target_y}), 32'd0);

    // Chase follows Pac-Man with one cycle of latency
    pac_x = 5'd3; pac_y = 5'd7;
    tick(); tick();
    chk("chase_tx", 32'(target_x), 32'd3);
    chk("chase_ty", 32'(target_y), 32'd7);
    pac_x = 5'd4; tick(); tick();
    chk("chase_tx2", 32'(target_x), 32'd4);

    // Scatter / chase edges
    chase = 0; tick();
    chk("scatter_rev", 32'(reverse), 32'd1);
    chk("scatter_mode", 32'(mode), 32'd0);
    tick();
    chk("scatter_rev_off", 32'(reverse), 32'd0);
    chk("scatter_tx", 32'(target_x), 32'd27);
    chase = 1; tick();
    chk("chase_rev", 32'(reverse), 32'd1);
    tick(); tick();

    // Full fright countdown
    step(1, 0, 0, 0);
    chk("fright_mode", 32'(mode), 32'd2);
    chk("fright_rev", 32'(reverse), 32'd1);
    tick();
    for (int i = 1; i <= 6; i++) begin
      strobe_and_gap();
      if (i == 3) chk("flash_cnt3", 32'(frightened_flash), 32'd0);
      if (i == 4) chk("flash_cnt2", 32'(frightened_flash), 32'd1);
    end
    chk("fright_exit_mode", 32'(mode), 32'd1);
    chk("fright_exit_rev", 32'(reverse), 32'd0);

    // Reload during fright, chase toggles ignored, exit follows chase
    step(1, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) strobe_and_gap();
    step(1, 0, 0, 0);
    chk("reload_flash", 32'(frightened_flash), 32'd0);
    chk("reload_rev", 32'(reverse), 32'd0);
    chase = 0; tick();
    chk("fright_toggle_rev", 32'(reverse), 32'd0);
    chase = 1; tick(); chase = 0; tick();
    for (int i = 0; i < 6; i++) strobe_and_gap();
    chk("exit_scatter", 32'(mode), 32'd0);

    // Eaten path
    step(1, 0, 0, 0); tick();
    step(0, 1, 0, 0);
    chk("eaten_mode", 32'(mode), 32'd3);
    tick();
    chk("eaten_tx", 32'(target_x), 32'd13);
    chk("eaten_ty", 32'(target_y), 32'd14);
    step(1, 0, 0, 1);
    chase = 1; tick(); chase = 0; tick(); chase = 1; tick();
    chk("eaten_hold", 32'(mode), 32'd3);
    step(0, 0, 1, 0);
    chk("home_mode", 32'(mode), 32'd1);
    chk("home_rev", 32'(reverse), 32'd0);
    tick();

    // Pellet plus chase edge together, then reset mid-fright
    chase = 0; step(1, 0, 0, 0);
    chk("combo_mode", 32'(mode), 32'd2);
    chk("combo_rev", 32'(reverse), 32'd1);
    tick();
    chk("combo_single", 32'(reverse), 32'd0);
    for (int i = 0; i < 4; i++) strobe_and_gap();
    reset = 1; tick(); reset = 0;
    chk("reset_fright_mode", 32'(mode), 32'd1);
    chk("reset_fright_flash", 32'(frightened_flash), 32'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      pac_x = 5'($urandom); pac_y = 5'($urandom);
      if ($urandom_range(15, 0) == 0) chase = ~chase;
      reset         = ($urandom_range(199, 0) == 0);
      pellet_eaten  = ($urandom_range(19, 0) == 0);
      ghost_eaten   = ($urandom_range(9, 0) == 0);
      ghost_at_home = ($urandom_range(9, 0) == 0);
      one_hz_enable = ($urandom_range(3, 0) == 0);
      tick();
    end
    reset = 0; pellet_eaten = 0; ghost_eaten = 0; ghost_at_home = 0; one_hz_enable = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
